rr_arb_mux_4_1: RTL and testbench
=================================

Name: rr_arb_mux_4_1

Overview:
- Registered 4-input round-robin arbiter plus data mux.
- Four upstream producers each present a WIDTH-bit word under a valid/ready handshake.
- The block grants one producer per accepted transfer, steers its word through the 4:1 data path, and holds the result in a single output register with its own valid/ready handshake.
- It sits directly upstream of the team's 4:1 mux consumers: out_sel is the 2-bit select index recorded with each word.

Parameters:
- WIDTH, 4, data width of every input word and of out_data.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  4  bit i set: producer i offers d_i.
- d0  input  WIDTH  producer 0 data.
- d1  input  WIDTH  producer 1 data.
- d2  input  WIDTH  producer 2 data.
- d3  input  WIDTH  producer 3 data.
- in_ready  output  4  one-hot or zero; bit i set: d_i is accepted this cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered word.
- out_sel  output  2  index of the producer that supplied out_data.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high. No other clocks or resets.
- Reset values (immediately on rst=1, independent of clk):
  - out_valid=0, out_data=0, out_sel=0.
  - Priority pointer ptr=0, so producer 0 has highest priority first.
- Accept condition: can_accept = !out_valid | out_ready. This is combinational, which gives full throughput of one word per cycle.
- Grant (combinational):
  - Scan in_valid starting at index ptr, then ptr+1, ptr+2, ptr+3, all mod 4.
  - The first set bit is grant index g.
  - If no bit is set, there is no grant.
- in_ready[i] = can_accept & (a grant exists) & (g==i). in_ready is zero during rst.
- On a rising edge with can_accept=1 and a grant:
  - out_data<=d_g, out_sel<=g, out_valid<=1.
  - ptr<=(g+1) mod 4; the just-served producer drops to lowest priority.
- On a rising edge with can_accept=1 and no grant: out_valid<=0. out_data, out_sel and ptr hold.
- On a rising edge with can_accept=0: all state holds; in_ready=0000.
- Simultaneous drain and refill (out_valid=1, out_ready=1, requester valid): the old word leaves and the new word loads on the same edge, with no bubble.
- Latency: input handshake in cycle N gives out_valid=1 with that word in cycle N+1.
- ptr advances only on an accepted transfer. A higher-priority producer becoming valid before a pending one is accepted may take the grant; this is legal.
- Fairness: a producer holding in_valid=1 continuously is accepted within 4 accepted transfers.
- Producer rule: once in_valid[i]=1, the producer holds it and d_i stable until in_ready[i]=1.
- Consumer rule: out_data and out_sel are stable while out_valid=1 and out_ready=0.
- Reset mid-operation: any registered word is discarded, and no in_ready is asserted while rst=1. After release, arbitration restarts from producer 0.
- Arithmetic: ptr and g are 2-bit and wrap 3→0 naturally.
- Producers outside in_valid are ignored; their d_i values are don't-care.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with out_valid=1 and out_data=4'h7. Required: out_valid=0, out_data=0, out_sel=0 before the next edge, in_ready=0000 while rst=1. After release with in_valid=1111, first grant is producer 0.
- Single producer: in_valid=0100, d2=4'hA, out_ready=1. Required: in_ready=0100 in that cycle. Next cycle out_valid=1, out_data=4'hA, out_sel=2. With in_valid then 0000, out_valid=0 the following cycle.
- Full rotation: in_valid=1111 held, d0..d3=1,2,3,4, out_ready=1. Required: out_sel sequence 0,1,2,3,0 and out_data sequence 1,2,3,4,1 on consecutive cycles, with no gaps.
- Backpressure: out_valid=1 with out_data=3, out_ready=0 for 3 cycles, in_valid=1111. Required: in_ready=0000 and out_data/out_sel unchanged for those cycles. In the cycle out_ready returns to 1, in_ready is one-hot and the next word appears the following cycle.
- Pointer wrap: after a grant to producer 1, set in_valid=1001. Required: grant to producer 3 first, then producer 0.
- Hold rule: in_valid=0010 with d1=4'h5 and out_ready=0 while the register is full. Required: producer 1 is accepted with out_data=4'h5 once out_ready=1; no word is lost or duplicated.

Source files
------------

// File: rtl/rr_arb_mux_4_1_if.sv
// rr_arb_mux_4_1_if
// Handshake bundle for the 4-input round-robin arbiter/mux.
//   in_valid  [3:0]       producer i offers d<i>
//   d0..d3    [WIDTH-1:0] producer data words
//   in_ready  [3:0]       one-hot (or zero) accept strobe back to producers
//   out_valid             output register holds a word
//   out_data  [WIDTH-1:0] registered word
//   out_sel   [1:0]       index of the producer that supplied out_data
//   out_ready             downstream accepts out_data this cycle
// Modports:
//   master - producers and consumer (drive in_valid/d*/out_ready)
//   slave  - the arbiter itself
interface rr_arb_mux_4_1_if #(
  parameter int WIDTH = 4
);
  logic [3:0]       in_valid;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;
  logic             out_ready;

  modport master (
    output in_valid, d0, d1, d2, d3, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, d0, d1, d2, d3, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_arb_mux_4_1.sv
// rr_arb_mux_4_1
// Registered 4-input round-robin arbiter plus 4:1 data mux. One producer is
// granted per accepted transfer; its word and index are captured in a single
// output register with its own valid/ready handshake. A new word may load on
// the same edge the old one drains, giving one word per cycle.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - rr_arb_mux_4_1_if.slave (in_valid, d0..d3, in_ready,
//          out_valid, out_data, out_sel, out_ready)
module rr_arb_mux_4_1 #(
  parameter int WIDTH = 4
) (
  input logic              clk,
  input logic              rst,
  rr_arb_mux_4_1_if.slave  bus
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       sel_q;
  logic [1:0]       ptr;        // highest-priority producer index

  logic             can_accept;
  logic             grant_any;
  logic [1:0]       g;
  logic [1:0]       idx;
  logic [WIDTH-1:0] d_g;

  // Register is free if empty or being drained this cycle.
  assign can_accept = !valid_q || bus.out_ready;

  // Scan from ptr+3 down to ptr so the lowest offset (closest to ptr) wins
  // by being assigned last.
  // NOTE: every variable written in always_comb gets a default first;
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    grant_any = 1'b0;
    g         = ptr;
    idx       = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (bus.in_valid[idx]) begin
        grant_any = 1'b1;
        g         = idx;
      end
    end
  end

  always_comb begin
    d_g = bus.d0;
    case (g)
      2'd0: d_g = bus.d0;
      2'd1: d_g = bus.d1;
      2'd2: d_g = bus.d2;
      2'd3: d_g = bus.d3;
    endcase
  end

  // Gated by rst so no producer sees an accept while the block is in reset.
  assign bus.in_ready = (can_accept && grant_any && !rst) ? (4'b0001 << g) : 4'b0000;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= 2'd0;
      ptr     <= 2'd0;
    end else if (can_accept) begin
      if (grant_any) begin
        valid_q <= 1'b1;
        data_q  <= d_g;
        sel_q   <= g;
        ptr     <= g + 2'd1;   // served producer drops to lowest priority
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// tb_rr_arb_mux_4_1
// Self-checking bench for rr_arb_mux_4_1. A reference model of the priority
// pointer predicts each grant; accepted words are pushed to a scoreboard
// queue and popped when the output handshake completes.
module tb_rr_arb_mux_4_1;
  localparam int WIDTH = 4;

  logic clk;
  logic rst;

  rr_arb_mux_4_1_if #(.WIDTH(WIDTH)) bus ();

  rr_arb_mux_4_1 #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [1:0]       m_ptr;
  logic [5:0]       sb[$];       // {sel, data}
  logic [1:0]       seen_sel[$]; // sel of every word that left the output
  logic [WIDTH-1:0] seen_data[$];

  function automatic logic [WIDTH-1:0] word_of(input logic [1:0] i);
    case (i)
      2'd0: return bus.d0;
      2'd1: return bus.d1;
      2'd2: return bus.d2;
      default: return bus.d3;
    endcase
  endfunction

  // Called at posedge+1 once this cycle's inputs are set. Samples at
  // posedge+2, compares, updates the model, then advances one clock.
  task automatic tick(input string tag);
    logic [3:0] exp_rdy;
    logic [1:0] g;
    logic [1:0] i;
    bit         found;
    bit         can;
    #1;
    found = 0;
    g     = m_ptr;
    for (int k = 0; k < 4; k++) begin
      i = m_ptr + 2'(k);
      if (!found && bus.in_valid[i]) begin
        found = 1;
        g     = i;
      end
    end
    can     = (sb.size() == 0) || (bus.out_ready === 1'b1);
    exp_rdy = (can && found) ? (4'b0001 << g) : 4'b0000;

    total_cnt++;
    if (bus.in_ready !== exp_rdy)
      $display("FAIL %s in_ready: got %b required %b", tag, bus.in_ready, exp_rdy);
    else pass_cnt++;

    total_cnt++;
    if (bus.out_valid !== (sb.size() != 0))
      $display("FAIL %s out_valid: got %b required %b", tag, bus.out_valid, sb.size() != 0);
    else pass_cnt++;

    if (sb.size() != 0) begin
      total_cnt++;
      if ({bus.out_sel, bus.out_data} !== sb[0])
        $display("FAIL %s out_sel/out_data: got %0d/%h required %0d/%h", tag,
                 bus.out_sel, bus.out_data, sb[0][5:4], sb[0][3:0]);
      else pass_cnt++;
      if (bus.out_ready === 1'b1) begin
        seen_sel.push_back(sb[0][5:4]);
        seen_data.push_back(sb[0][3:0]);
        void'(sb.pop_front());
      end
    end

    if (can && found) begin
      sb.push_back({g, word_of(g)});
      m_ptr = g + 2'd1;
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle; checks happen before the next edge.
  task automatic do_reset();
    bus.in_valid = 4'b1111;
    #3;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_sel !== 2'd0)
      $display("FAIL reset_async outputs: got v=%b d=%h s=%0d required v=0 d=0 s=0",
               bus.out_valid, bus.out_data, bus.out_sel);
    else pass_cnt++;
    total_cnt++;
    if (bus.in_ready !== 4'b0000)
      $display("FAIL reset_in_ready: got %b required 0000", bus.in_ready);
    else pass_cnt++;
    sb.delete();
    m_ptr = 2'd0;
    @(posedge clk);
    #1;
    total_cnt++;
    if (bus.in_ready !== 4'b0000 || bus.out_valid !== 1'b0)
      $display("FAIL reset_held: got in_ready=%b out_valid=%b required 0000/0",
               bus.in_ready, bus.out_valid);
    else pass_cnt++;
    rst = 1'b0;
    bus.in_valid = 4'b0000;
  endtask

  task automatic test_reset();
    bus.in_valid = 4'b0001; bus.d0 = 4'h7; bus.out_ready = 1'b0;
    tick("reset_load7");
    bus.in_valid = 4'b0000;
    tick("reset_hold7");
    total_cnt++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h7)
      $display("FAIL reset_pre: got v=%b d=%h required v=1 d=7", bus.out_valid, bus.out_data);
    else pass_cnt++;
    do_reset();
    bus.in_valid = 4'b1111;
    bus.d0 = 4'h1; bus.d1 = 4'h2; bus.d2 = 4'h3; bus.d3 = 4'h4;
    bus.out_ready = 1'b1;
    total_cnt++;
    #1;
    if (bus.in_ready !== 4'b0001)
      $display("FAIL reset_first_grant: got %b required 0001", bus.in_ready);
    else pass_cnt++;
    tick("reset_first");
    bus.in_valid = 4'b0000;
    tick("reset_drain");
    tick("reset_idle");
  endtask

  task automatic test_single();
    bus.in_valid = 4'b0100; bus.d2 = 4'hA; bus.out_ready = 1'b1;
    tick("single_req");
    bus.in_valid = 4'b0000;
    total_cnt++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 4'hA || bus.out_sel !== 2'd2)
      $display("FAIL single_out: got v=%b d=%h s=%0d required v=1 d=a s=2",
               bus.out_valid, bus.out_data, bus.out_sel);
    else pass_cnt++;
    tick("single_drain");
    tick("single_empty");
  endtask

  task automatic test_rotation();
    logic [1:0] exp_sel[5];
    int         base;
    exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    bus.d0 = 4'h1; bus.d1 = 4'h2; bus.d2 = 4'h3; bus.d3 = 4'h4;
    bus.out_ready = 1'b1;
    bus.in_valid = 4'b1111;
    base = seen_sel.size();
    for (int n = 0; n < 5; n++) tick("rotation");
    bus.in_valid = 4'b0000;
    tick("rotation_drain");
    tick("rotation_idle");
    for (int n = 0; n < 5; n++) begin
      total_cnt++;
      if (seen_sel.size() < base + 5)
        $display("FAIL rotation_count: got %0d words required 5", seen_sel.size() - base);
      else if (seen_sel[base+n] !== exp_sel[n] || seen_data[base+n] !== 4'(exp_sel[n]) + 4'h1)
        $display("FAIL rotation_seq[%0d]: got sel %0d data %h required sel %0d data %h", n,
                 seen_sel[base+n], seen_data[base+n], exp_sel[n], 4'(exp_sel[n]) + 4'h1);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    bus.in_valid = 4'b0100; bus.d2 = 4'h3; bus.out_ready = 1'b1;
    tick("bp_load3");
    bus.in_valid = 4'b1111; bus.out_ready = 1'b0;
    for (int n = 0; n < 3; n++) tick("bp_stall");
    total_cnt++;
    if (bus.out_data !== 4'h3 || bus.out_sel !== 2'd2)
      $display("FAIL bp_held: got d=%h s=%0d required d=3 s=2", bus.out_data, bus.out_sel);
    else pass_cnt++;
    bus.out_ready = 1'b1;
    tick("bp_release");
    bus.in_valid = 4'b0000;
    tick("bp_drain");
    tick("bp_idle");
  endtask

  task automatic test_wrap();
    int base;
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid = 4'b0010; bus.d1 = 4'h5;
    tick("wrap_p1");
    base = seen_sel.size();
    bus.in_valid = 4'b1001; bus.d0 = 4'h8; bus.d3 = 4'hC;
    tick("wrap_p3");
    bus.in_valid = 4'b0001;
    tick("wrap_p0");
    bus.in_valid = 4'b0000;
    tick("wrap_drain");
    tick("wrap_idle");
    total_cnt++;
    if (seen_sel.size() < base + 3)
      $display("FAIL wrap_count: got %0d words required 3", seen_sel.size() - base);
    else if (seen_sel[base+1] !== 2'd3 || seen_sel[base+2] !== 2'd0)
      $display("FAIL wrap_order: got %0d,%0d required 3,0", seen_sel[base+1], seen_sel[base+2]);
    else pass_cnt++;
  endtask

  task automatic test_hold();
    int base;
    base = seen_sel.size();
    bus.in_valid = 4'b0001; bus.d0 = 4'h9; bus.out_ready = 1'b0;
    tick("hold_fill");
    bus.in_valid = 4'b0010; bus.d1 = 4'h5;
    tick("hold_wait");
    tick("hold_wait");
    bus.out_ready = 1'b1;
    tick("hold_accept");
    bus.in_valid = 4'b0000;
    tick("hold_drain");
    tick("hold_idle");
    total_cnt++;
    if (seen_sel.size() != base + 2 || sb.size() != 0)
      $display("FAIL hold_count: got %0d words (%0d pending) required 2 (0)",
               seen_sel.size() - base, sb.size());
    else if (seen_sel[base+1] !== 2'd1 || seen_data[base+1] !== 4'h5)
      $display("FAIL hold_word: got sel %0d data %h required sel 1 data 5",
               seen_sel[base+1], seen_data[base+1]);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 4'b0000;
    bus.d0 = '0; bus.d1 = '0; bus.d2 = '0; bus.d3 = '0;
    bus.out_ready = 1'b0;
    m_ptr = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_wrap();
    test_hold();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
